// File: rtl/mod_updown_counter_if.sv
// rtl/mod_updown_counter_if.sv - control/status bundle for the up/down counter
interface mod_updown_counter_if #(
  parameter int WIDTH = 5
);
  logic             en;
  logic             up_dn;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrapped;

  modport master (
    output en, up_dn, clear, load, load_val,
    input  q, tc, wrapped
  );

  modport slave (
    input  en, up_dn, clear, load, load_val,
    output q, tc, wrapped
  );
endinterface

// File: rtl/mod_updown_counter.sv
// rtl/mod_updown_counter.sv - modulo up/down counter with wrap or saturate, tc pulse and sticky wrap flag
module mod_updown_counter #(
  parameter int     WIDTH  = 5,
  parameter longint MODULO = 32,
  parameter bit     SAT_EN = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  mod_updown_counter_if.slave  bus
);
  // Highest legal count, one bit wider so MODULO = 2^WIDTH still fits.
  localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MODULO - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             wrapped_q, wrapped_d;

  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   q_inc;
  logic [WIDTH:0]   q_dec;
  logic [WIDTH:0]   ld_ext;
  logic             up_hit;
  logic             dn_hit;

  assign q_ext  = {1'b0, q_q};
  assign q_inc  = q_ext + 1'b1;
  assign q_dec  = q_ext - 1'b1;
  assign ld_ext = {1'b0, bus.load_val};
  // Ends detected from the widened results: passing LAST going up, borrow going down.
  assign up_hit = (q_inc > LAST);
  assign dn_hit = q_dec[WIDTH];

  always_comb begin
    q_d       = q_q;
    tc_d      = 1'b0;
    wrapped_d = wrapped_q;
    if (bus.clear) begin
      q_d       = '0;
      wrapped_d = 1'b0;
    end else if (bus.load) begin
      q_d = (ld_ext > LAST) ? LAST[WIDTH-1:0] : bus.load_val;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (up_hit) begin
          tc_d      = 1'b1;
          wrapped_d = 1'b1;
          q_d       = SAT_EN ? q_q : '0;
        end else begin
          q_d = q_inc[WIDTH-1:0];
        end
      end else begin
        if (dn_hit) begin
          tc_d      = 1'b1;
          wrapped_d = 1'b1;
          q_d       = SAT_EN ? q_q : LAST[WIDTH-1:0];
        end else begin
          q_d = q_dec[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q       <= '0;
      tc_q      <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      tc_q      <= tc_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.tc      = tc_q;
  assign bus.wrapped = wrapped_q;
endmodule

// File: tb/tb_mod_updown_counter.sv
// tb/tb_mod_updown_counter.sv - self-checking bench: default, MODULO=10 and saturating counters side by side
module tb_mod_updown_counter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0, up_dn = 1'b1, clear = 1'b0, load = 1'b0;
  logic [4:0] load_val = '0;

  int errors = 0;
  int checks = 0;

  mod_updown_counter_if #(.WIDTH(5)) if0 ();
  mod_updown_counter_if #(.WIDTH(5)) if1 ();
  mod_updown_counter_if #(.WIDTH(5)) if2 ();

  assign if0.en = en;  assign if0.up_dn = up_dn;  assign if0.clear = clear;
  assign if0.load = load;  assign if0.load_val = load_val;
  assign if1.en = en;  assign if1.up_dn = up_dn;  assign if1.clear = clear;
  assign if1.load = load;  assign if1.load_val = load_val;
  assign if2.en = en;  assign if2.up_dn = up_dn;  assign if2.clear = clear;
  assign if2.load = load;  assign if2.load_val = load_val;

  mod_updown_counter #(.WIDTH(5), .MODULO(32), .SAT_EN(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  mod_updown_counter #(.WIDTH(5), .MODULO(10), .SAT_EN(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  mod_updown_counter #(.WIDTH(5), .MODULO(32), .SAT_EN(1'b1)) dut2 (.clk(clk), .reset(reset), .bus(if2));

  logic [4:0] dq [3];
  logic       dtc [3];
  logic       dwr [3];
  assign dq[0] = if0.q;  assign dtc[0] = if0.tc;  assign dwr[0] = if0.wrapped;
  assign dq[1] = if1.q;  assign dtc[1] = if1.tc;  assign dwr[1] = if1.wrapped;
  assign dq[2] = if2.q;  assign dtc[2] = if2.tc;  assign dwr[2] = if2.wrapped;

  always #5 clk = ~clk;

  // Reference model: plain integer counting, one entry per configuration
  int mods [3] = '{32, 10, 32};
  bit sats [3] = '{1'b0, 1'b0, 1'b1};
  int m_q  [3];
  bit m_tc [3];
  bit m_wr [3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_q[k] = 0; m_tc[k] = 0; m_wr[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      int top;
      top = mods[k] - 1;
      m_tc[k] = 0;
      if (clear) begin
        m_q[k] = 0; m_wr[k] = 0;
      end else if (load) begin
        m_q[k] = (int'(load_val) < mods[k]) ? int'(load_val) : top;
      end else if (en) begin
        if (up_dn && m_q[k] == top) begin
          m_tc[k] = 1; m_wr[k] = 1;
          if (!sats[k]) m_q[k] = 0;
        end else if (!up_dn && m_q[k] == 0) begin
          m_tc[k] = 1; m_wr[k] = 1;
          if (!sats[k]) m_q[k] = top;
        end else begin
          m_q[k] = up_dn ? m_q[k] + 1 : m_q[k] - 1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s dut%0d q", tag, k), int'(dq[k]), m_q[k]);
      chk($sformatf("%s dut%0d tc", tag, k), int'(dtc[k]), int'(m_tc[k]));
      chk($sformatf("%s dut%0d wrapped", tag, k), int'(dwr[k]), int'(m_wr[k]));
    end
  endtask

  task automatic step(input bit e, input bit u, input bit c, input bit l, input logic [4:0] v, input string tag);
    en = e; up_dn = u; clear = c; load = l; load_val = v;
    @(posedge clk);
    model_edge();
    #1;
    chk_model(tag);
  endtask

  typedef struct {
    bit         e, u, c, l;
    logic [4:0] v;
    int         xq;
    bit         xtc, xwr;
  } vec_t;

  vec_t vecs [14];

  initial begin
    // Expected values below are for the default (MODULO=32, wrap) counter
    vecs[0]  = '{0,1,0,1,5'd30, 30,0,0};
    vecs[1]  = '{1,1,0,0,5'd0,  31,0,0};
    vecs[2]  = '{1,1,0,0,5'd0,   0,1,1};
    vecs[3]  = '{1,1,0,0,5'd0,   1,0,1};
    vecs[4]  = '{1,0,0,0,5'd0,   0,0,1};
    vecs[5]  = '{1,0,0,0,5'd0,  31,1,1};
    vecs[6]  = '{0,0,0,0,5'd0,  31,0,1};
    vecs[7]  = '{1,1,1,1,5'd5,   0,0,0};
    vecs[8]  = '{0,1,0,1,5'd5,   5,0,0};
    vecs[9]  = '{1,1,0,0,5'd0,   6,0,0};
    vecs[10] = '{0,0,0,0,5'd0,   6,0,0};
    vecs[11] = '{1,0,0,0,5'd0,   5,0,0};
    vecs[12] = '{0,1,0,1,5'd31, 31,0,0};
    vecs[13] = '{1,1,0,1,5'd31, 31,0,0};

    model_reset();
    #1;
    chk_model("reset");
    #19;
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].e, vecs[i].u, vecs[i].c, vecs[i].l, vecs[i].v, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d q", i), int'(dq[0]), vecs[i].xq);
      chk($sformatf("vec%0d tc", i), int'(dtc[0]), int'(vecs[i].xtc));
      chk($sformatf("vec%0d wrapped", i), int'(dwr[0]), int'(vecs[i].xwr));
    end

    // Full up-count on the default counter: 0..31 then back to 0 with tc
    step(0, 1, 1, 0, 5'd0, "clr_a");
    for (int i = 1; i <= 32; i++) begin
      step(1, 1, 0, 0, 5'd0, "upcnt");
      chk("upcnt q", int'(dq[0]), i % 32);
      chk("upcnt tc", int'(dtc[0]), (i == 32) ? 1 : 0);
    end
    chk("upcnt wrapped", int'(dwr[0]), 1);

    // MODULO=10 down-count from 0: 9,8,...,0,9
    step(0, 1, 1, 0, 5'd0, "clr_b");
    for (int i = 1; i <= 11; i++) begin
      step(1, 0, 0, 0, 5'd0, "dncnt");
      chk("dncnt q", int'(dq[1]), (10 - (i % 10)) % 10);
      chk("dncnt tc", int'(dtc[1]), (i == 1 || i == 11) ? 1 : 0);
    end

    // Load clamping and clear-over-load on MODULO=10
    step(0, 1, 0, 1, 5'd13, "ld13");
    chk("ld13 q", int'(dq[1]), 9);
    step(0, 1, 1, 1, 5'd13, "ldclr");
    chk("ldclr q", int'(dq[1]), 0);
    chk("ldclr wrapped", int'(dwr[1]), 0);

    // Saturation on the SAT_EN counter
    step(0, 1, 0, 1, 5'd30, "sat_ld");
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 5'd0, "sat_up");
      chk("sat_up q", int'(dq[2]), 31);
      chk("sat_up tc", int'(dtc[2]), (i == 0) ? 0 : 1);
    end
    step(0, 1, 0, 1, 5'd1, "sat_ld1");
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 0, 5'd0, "sat_dn");
      chk("sat_dn q", int'(dq[2]), 0);
      chk("sat_dn tc", int'(dtc[2]), i);
    end

    // Asynchronous reset mid-cycle at q=17 with wrapped set
    step(1, 0, 1, 0, 5'd0, "pre_clr");
    step(1, 0, 0, 0, 5'd0, "pre_wrap");
    step(0, 1, 0, 1, 5'd17, "ld17");
    chk("ld17 q", int'(dq[0]), 17);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async q", int'(dq[0]), 0);
    chk("async tc", int'(dtc[0]), 0);
    chk("async wrapped", int'(dwr[0]), 0);
    chk_model("async");
    en = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 5'd9;
    repeat (2) @(posedge clk);
    #1;
    chk_model("held");
    load = 1'b0;
    reset = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      step(1, 1, 0, 0, 5'd0, "resume");
      chk("resume q", int'(dq[0]), i);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit          r_c, r_l, r_e, r_u;
      logic [4:0]  r_v;
      r_c = ($urandom_range(0, 39) == 0);
      r_l = ($urandom_range(0, 9) == 0);
      r_e = ($urandom_range(0, 9) < 8);
      r_u = ($urandom_range(0, 9) < 6) ^ (i >= 200);
      r_v = 5'($urandom_range(0, 31));
      step(r_e, r_u, r_c, r_l, r_v, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 Parameter WIDTH, default 5: counter width in bits; legal range 2..32.
REQ-002 Parameter MODULO, default 32: count sequence length; legal range 2..2^WIDTH; count range 0..MODULO-1.
REQ-003 Parameter SAT_EN, default 0: 0 = wrap at range ends; 1 = saturate at range ends.
REQ-004 clk  input  1  rising-edge clock; the only clock.
REQ-005 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-006 en  input  1  count enable; high = one step per clock.
REQ-007 up_dn  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 clear  input  1  synchronous clear to 0.
REQ-009 load  input  1  synchronous parallel load.
REQ-010 load_val  input  WIDTH  value captured when load is high.
REQ-011 q  output  WIDTH  registered count value.
REQ-012 tc  output  1  registered terminal-count pulse: high for one cycle after a wrap or saturation hit.
REQ-013 wrapped  output  1  sticky flag: set by any wrap or saturation event.

Function
REQ-014 All state updates SHALL occur on the rising edge of clk; q, tc and wrapped SHALL be registered outputs with no combinational path from inputs.
REQ-015 Priority per edge SHALL be clear > load > en; lower-priority requests in the same cycle are ignored.
REQ-016 clear: q <= 0, tc <= 0, wrapped <= 0.
REQ-017 load: q <= load_val if load_val < MODULO, else q <= MODULO-1 (clamp); tc <= 0; wrapped unchanged.
REQ-018 en, up_dn=1, q < MODULO-1: q <= q+1, tc <= 0.
REQ-019 en, up_dn=1, q = MODULO-1, SAT_EN=0: q <= 0, tc <= 1, wrapped <= 1.
REQ-020 en, up_dn=0, q > 0: q <= q-1, tc <= 0.
REQ-021 en, up_dn=0, q = 0, SAT_EN=0: q <= MODULO-1, tc <= 1, wrapped <= 1.
REQ-022 SAT_EN=1 at an end (q = MODULO-1 up, or q = 0 down): q holds; tc <= 1 on every such enabled edge; wrapped <= 1.
REQ-023 en=0 with no clear or load: q and wrapped hold; tc <= 0.
REQ-024 Latency: q and tc reflect a request on the same rising edge that samples it (one-cycle register latency from input to output).
REQ-025 Arithmetic SHALL be computed at WIDTH+1 bits internally; q SHALL never hold a value >= MODULO.
REQ-026 When MODULO = 2^WIDTH, behaviour SHALL equal natural binary wrap (default config: 31 -> 0 counting up).
REQ-027 Direction changes between cycles SHALL take effect on the next enabled edge with no dead cycle.

Reset
REQ-028 reset low SHALL immediately (no clock required) force q = 0, tc = 0, wrapped = 0.
REQ-029 While reset is low, all inputs SHALL be ignored.
REQ-030 After reset deasserts, the first rising edge SHALL process inputs normally; deassertion mid-count resumes counting from 0.
REQ-031 Reset asserted mid-operation (during load, clear or wrap) SHALL override all of them.

Verification
REQ-032 Defaults, reset low 15 ns then high, en=1, up_dn=1, 10 ns clock -> q steps 0,1,...,31,0; tc high exactly the cycle q returns to 0; wrapped=1 afterwards.
REQ-033 MODULO=10, en=1, up_dn=0 from q=0 -> q = 9,8,...,0,9; tc pulses on each 0->9 transition.
REQ-034 MODULO=10, load=1, load_val=13 -> q=9; load=1 with clear=1 in the same cycle -> q=0, wrapped=0.
REQ-035 SAT_EN=1, defaults, count up from 30 -> q = 31,31,31; tc high on each enabled edge at 31; down from 1 -> 0,0 with tc high at 0.
REQ-036 reset pulled low asynchronously mid-cycle at q=17 -> q=0, tc=0, wrapped=0 before the next clock edge; after release, count resumes 1,2,...
REQ-037 en toggled 1,0,1 with up_dn flipped between edges from q=5 -> q = 6,6,5; tc stays 0.
